// File: rtl/light_sequencer.sv
// Steps the light-manager sel code through a latched first..last range, holding
// each code for TICK_DIV cycles, once or looping, with stop/start control.
module light_sequencer #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       dir,
  input  logic       loop,
  input  logic [5:0] first,
  input  logic [5:0] last,
  output logic [5:0] sel,
  output logic       busy,
  output logic       step,
  output logic       done
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d, loop_q, loop_d;
  logic [5:0]       first_q, first_d, last_q, last_d;
  logic [5:0]       sel_q, sel_d;
  logic             step_q, step_d, done_q, done_d;

  logic tick, at_last;
  assign tick    = (cnt_q == CNT_MAX);
  assign at_last = (sel_q == last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      loop_q  <= 1'b0;
      first_q <= '0;
      last_q  <= '0;
      sel_q   <= '0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      loop_q  <= loop_d;
      first_q <= first_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  // stop wins over start and over the tick event
  always_comb begin
    state_d = state_q;
    if (stop)
      state_d = IDLE;
    else if (state_q == IDLE && start)
      state_d = RUN;
    else if (state_q == RUN && tick && at_last && !loop_q)
      state_d = IDLE;
  end

  always_comb begin
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    loop_d  = loop_q;
    first_d = first_q;
    last_d  = last_q;
    sel_d   = sel_q;
    step_d  = 1'b0;
    done_d  = 1'b0;
    if (!stop) begin
      if (state_q == IDLE) begin
        if (start) begin
          dir_d   = dir;
          loop_d  = loop;
          first_d = first;
          last_d  = last;
          sel_d   = first;
          step_d  = 1'b1;
          cnt_d   = '0;
        end
      end else if (tick) begin
        cnt_d = '0;
        if (!at_last) begin
          // 6-bit arithmetic gives the 63<->0 wrap for free
          sel_d  = dir_q ? sel_q - 6'd1 : sel_q + 6'd1;
          step_d = 1'b1;
        end else if (loop_q) begin
          sel_d  = first_q;
          step_d = 1'b1;
        end else begin
          done_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign sel  = sel_q;
  assign busy = (state_q == RUN);
  assign step = step_q;
  assign done = done_q;
endmodule

// File: tb/tb_light_sequencer.sv
// Four sequencers (TICK_DIV 1..4) share stimulus; a list-based reference model
// checks all of them every cycle, with directed tables/sequences for corners.
module tb_light_sequencer;
  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst_n, start, stop, dir, loop;
  logic [5:0] first, last;
  logic [5:0] sel_o [NI];
  logic       busy_o[NI], step_o[NI], done_o[NI];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    light_sequencer #(.TICK_DIV(k + 1)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir(dir),
      .loop(loop), .first(first), .last(last),
      .sel(sel_o[k]), .busy(busy_o[k]), .step(step_o[k]), .done(done_o[k])
    );
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sequence expanded into a code list, walked by index.
  logic       m_run [NI];
  logic       m_loop[NI];
  int         m_idx [NI], m_age[NI], m_len[NI];
  logic [5:0] m_seq [NI][64];
  logic [5:0] m_sel [NI];
  logic       m_step[NI], m_done[NI];

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_run[k] = 0; m_loop[k] = 0; m_idx[k] = 0; m_age[k] = 0; m_len[k] = 0;
      m_sel[k] = 0; m_step[k] = 0; m_done[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < NI; k++) begin
      m_step[k] = 0; m_done[k] = 0;
      if (stop) m_run[k] = 0;
      else if (!m_run[k]) begin
        if (start) begin
          int c = first;
          m_len[k] = 0;
          forever begin
            m_seq[k][m_len[k]] = 6'(c);
            m_len[k]++;
            if (c == int'(last)) break;
            c = dir ? (c + 63) % 64 : (c + 1) % 64;
          end
          m_loop[k] = loop; m_run[k] = 1; m_idx[k] = 0; m_age[k] = 0;
          m_sel[k] = first; m_step[k] = 1;
        end
      end else begin
        m_age[k]++;
        if (m_age[k] == k + 1) begin
          m_age[k] = 0;
          if (m_idx[k] + 1 < m_len[k]) begin
            m_idx[k]++; m_sel[k] = m_seq[k][m_idx[k]]; m_step[k] = 1;
          end else if (m_loop[k]) begin
            m_idx[k] = 0; m_sel[k] = m_seq[k][0]; m_step[k] = 1;
          end else begin
            m_run[k] = 0; m_done[k] = 1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("model sel[%0d]", k),  sel_o[k],  m_sel[k]);
      chk($sformatf("model busy[%0d]", k), busy_o[k], m_run[k]);
      chk($sformatf("model step[%0d]", k), step_o[k], m_step[k]);
      chk($sformatf("model done[%0d]", k), done_o[k], m_done[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) model_edge();
    check_all();
  endtask

  task automatic go_idle();
    start = 0; stop = 1; tick(); stop = 0;
  endtask

  task automatic expect_out(input string nm, input int k, input int s,
                            input int b, input int st, input int d);
    chk({nm, " sel"},  sel_o[k],  s);
    chk({nm, " busy"}, busy_o[k], b);
    chk({nm, " step"}, step_o[k], st);
    chk({nm, " done"}, done_o[k], d);
  endtask

  typedef struct {
    logic start, stop, dir, loop;
    logic [5:0] first, last;
    int e_sel, e_busy, e_step, e_done;
  } vec_t;

  function automatic vec_t v(input logic sa, so, di, lp, input logic [5:0] f, l,
                             input int es, eb, est, ed);
    vec_t r;
    r.start = sa; r.stop = so; r.dir = di; r.loop = lp; r.first = f; r.last = l;
    r.e_sel = es; r.e_busy = eb; r.e_step = est; r.e_done = ed;
    return r;
  endfunction

  vec_t tbl[19];

  initial begin
    // Up run 2..5 on TICK_DIV=4; includes start+stop in IDLE and a start/config change mid-run
    tbl[0]  = v(1, 1, 0, 0,  2,  5, 0, 0, 0, 0);
    tbl[1]  = v(1, 0, 0, 0,  2,  5, 2, 1, 1, 0);
    tbl[2]  = v(0, 0, 0, 0,  2,  5, 2, 1, 0, 0);
    tbl[3]  = v(0, 0, 0, 0,  2,  5, 2, 1, 0, 0);
    tbl[4]  = v(0, 0, 0, 0,  2,  5, 2, 1, 0, 0);
    tbl[5]  = v(0, 0, 0, 0,  2,  5, 3, 1, 1, 0);
    tbl[6]  = v(1, 0, 1, 1, 40, 41, 3, 1, 0, 0);
    tbl[7]  = v(0, 0, 1, 1, 40, 41, 3, 1, 0, 0);
    tbl[8]  = v(0, 0, 0, 0,  2,  5, 3, 1, 0, 0);
    tbl[9]  = v(0, 0, 0, 0,  2,  5, 4, 1, 1, 0);
    tbl[10] = v(0, 0, 0, 0,  2,  5, 4, 1, 0, 0);
    tbl[11] = v(0, 0, 0, 0,  2,  5, 4, 1, 0, 0);
    tbl[12] = v(0, 0, 0, 0,  2,  5, 4, 1, 0, 0);
    tbl[13] = v(0, 0, 0, 0,  2,  5, 5, 1, 1, 0);
    tbl[14] = v(0, 0, 0, 0,  2,  5, 5, 1, 0, 0);
    tbl[15] = v(0, 0, 0, 0,  2,  5, 5, 1, 0, 0);
    tbl[16] = v(0, 0, 0, 0,  2,  5, 5, 1, 0, 0);
    tbl[17] = v(0, 0, 0, 0,  2,  5, 5, 0, 0, 1);
    tbl[18] = v(0, 0, 0, 0,  2,  5, 5, 0, 0, 0);

    rst_n = 0; start = 0; stop = 0; dir = 0; loop = 0; first = 6'd9; last = 6'd9;
    model_reset();
    #2;
    for (int k = 0; k < NI; k++) expect_out("reset", k, 0, 0, 0, 0);
    #10 rst_n = 1;
    tick();

    for (int i = 0; i < 19; i++) begin
      start = tbl[i].start; stop = tbl[i].stop; dir = tbl[i].dir; loop = tbl[i].loop;
      first = tbl[i].first; last = tbl[i].last;
      tick();
      expect_out($sformatf("tbl[%0d]", i), 3, tbl[i].e_sel, tbl[i].e_busy,
                 tbl[i].e_step, tbl[i].e_done);
    end

    // Down with wrap on TICK_DIV=2: 1,0,63,62 then done
    go_idle();
    start = 1; first = 1; last = 62; dir = 1; loop = 0;
    tick(); expect_out("down e0", 1, 1, 1, 1, 0);
    start = 0;
    tick(); tick(); expect_out("down e2", 1, 0, 1, 1, 0);
    tick(); tick(); expect_out("down e4", 1, 63, 1, 1, 0);
    tick(); tick(); expect_out("down e6", 1, 62, 1, 1, 0);
    tick(); expect_out("down e7", 1, 62, 1, 0, 0);
    tick(); expect_out("down e8", 1, 62, 0, 0, 1);

    // Single-code loop on TICK_DIV=3, then stop
    go_idle();
    start = 1; first = 7; last = 7; dir = 0; loop = 1;
    tick(); expect_out("loop e0", 2, 7, 1, 1, 0);
    start = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      expect_out($sformatf("loop e%0d", i), 2, 7, 1, (i % 3 == 0) ? 1 : 0, 0);
    end
    stop = 1;
    tick(); expect_out("loop stop", 2, 7, 0, 0, 0);
    stop = 0;

    // Reset mid-run at sel=4 on TICK_DIV=4, then a clean restart
    go_idle();
    start = 1; first = 2; last = 5; dir = 0; loop = 0;
    tick(); start = 0;
    for (int i = 0; i < 8; i++) tick();
    expect_out("pre-rst", 3, 4, 1, 1, 0);
    #2 rst_n = 0; model_reset();
    #1;
    for (int k = 0; k < NI; k++) expect_out("mid-rst", k, 0, 0, 0, 0);
    tick(); tick();
    expect_out("held-rst", 3, 0, 0, 0, 0);
    #3 rst_n = 1;
    start = 1; first = 10; last = 11;
    tick(); expect_out("restart", 3, 10, 1, 1, 0);
    start = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      dir   = 1'($urandom_range(0, 1));
      loop  = ($urandom_range(0, 4) == 0);
      first = 6'($urandom_range(0, 63));
      last  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                          : 6'(dir ? first - 6'($urandom_range(0, 5))
                                                   : first + 6'($urandom_range(0, 5)));
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 0; model_reset();
        #1 check_all();
        #4 rst_n = 1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/light_sequencer.md
# light_sequencer

Sequencer that drives the 6-bit `sel` code of the light manager. Once started, it steps `sel` through a programmable range from `first` to `last`, counting up or down. Each code is held for a fixed number of clock cycles. The sequence runs once or loops until stopped. It sits between the game control logic and the light manager and reports progress through `busy`, `step` and `done`.

## Interface
- `TICK_DIV`, 50000: clock cycles each `sel` value is held; legal range 1..2^20.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request to begin a sequence; sampled only in IDLE.
- `stop` input 1: abort request; sampled in every state.
- `dir` input 1: step direction, 0 = up (+1), 1 = down (−1); latched at start.
- `loop` input 1: 1 = restart from `first` after `last`; latched at start.
- `first` input 6: first code of the range; latched at start.
- `last` input 6: last code of the range; latched at start.
- `sel` output 6: code fed to the light manager `sel` input; registered.
- `busy` output 1: high while in RUN.
- `step` output 1: one-cycle pulse on every cycle in which `sel` is loaded or changes.
- `done` output 1: one-cycle pulse when a non-looping sequence completes.

## Operation
- States: IDLE and RUN. All outputs are registered.
- `dir`, `loop`, `first` and `last` are copied into internal registers on start. Changing these inputs during RUN has no effect.
- Tick counter: width `$clog2(TICK_DIV)`, minimum 1 bit. It is cleared on entry to RUN and on every step, and counts up to `TICK_DIV−1`.
- **IDLE → RUN** when `start`=1 and `stop`=0:
  - `sel` ← `first`, `busy` ← 1, `step` ← 1, counter ← 0.
- **RUN**: when the counter equals `TICK_DIV−1`:
  - If `sel` ≠ latched `last`: `sel` ← `sel`±1 (modulo 64), `step` ← 1, counter ← 0.
  - If `sel` = `last` and loop=1: `sel` ← `first`, `step` ← 1, counter ← 0.
  - If `sel` = `last` and loop=0: go to IDLE, `busy` ← 0, `done` ← 1, `sel` holds its value.
- Wrap-around: codes wrap 63→0 when counting up and 0→63 when counting down.
  - The range is always traversed in `dir` order, so up with `first` > `last` passes through the wrap.
  - `first` = `last` gives a single code held for `TICK_DIV` cycles.
- `stop`=1 in any state: next state is IDLE, `busy` ← 0, `step` ← 0, `done` ← 0, `sel` holds.
  - `stop` has priority over `start` and over the tick event in the same cycle.
- `start` during RUN is ignored; there is no restart.
- Outside of transitions, `step` and `done` are 0.

## Timing
- Reset (`rst_n`=0, takes effect immediately): `sel`=0, `busy`=0, `step`=0, `done`=0, state IDLE, counter 0, latched config cleared to 0.
- Reset asserted mid-run aborts the sequence immediately; no `done` pulse is produced.
- Start latency: `start` sampled at edge N gives `sel`=`first`, `busy`=1 and `step`=1 after edge N.
- Each value is held for exactly `TICK_DIV` cycles: changes occur after edges N+TICK_DIV, N+2·TICK_DIV, …
- A range of K codes with loop=0 completes with `done` pulsing and `busy` falling after edge N+K·TICK_DIV.
- `TICK_DIV`=1: `sel` changes every cycle.
- Back-to-back runs: `start` held high in the cycle after `done` begins a new run; there is no dead cycle requirement beyond returning to IDLE.

## Test plan
- **Reset:** assert `rst_n`=0 mid-clock → `sel`=0, `busy`=0, `step`=0, `done`=0 without waiting for a clock edge.
- **Up run:** `TICK_DIV`=4, `first`=2, `last`=5, `dir`=0, `loop`=0, `start` at edge 0 → `sel` = 2, 3, 4, 5 after edges 0, 4, 8, 12; `step` pulses at each; `done`=1 and `busy`=0 after edge 16; `sel` stays 5.
- **Down with wrap:** `TICK_DIV`=2, `first`=1, `last`=62, `dir`=1 → `sel` = 1, 0, 63, 62 at 2-cycle spacing; `done` after edge 8.
- **Loop and stop:** `TICK_DIV`=3, `first`=`last`=7, `loop`=1 → `step` every 3 cycles, `sel`=7, no `done`. Then `stop` → `busy`=0 next cycle, `done`=0, `sel`=7.
- **Priority:** `start` and `stop` together in IDLE → stays IDLE, `busy`=0. `start` pulse and a change to `first` during RUN → sequence unaffected.
- **Reset mid-run:** `rst_n` asserted at `sel`=4 → all outputs return to reset values. A new `start` after release runs normally from `first`.
